dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // True when the access is misaligned, outside the window, or not exactly one of load/store.
  function automatic logic access_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic        memr,
    input logic        memw,
    input int unsigned depth
  );
    logic [31:0] off;
    off = addr - base;
    return (addr[WORD_SHIFT-1:0] != '0) ||
           (addr < base) ||
           ((off >> WORD_SHIFT) >= depth) ||
           (memr == memw);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read at the same index.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: req/ack handshake, programmable wait states, error flagging.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        memr,
  input  logic        memw,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] addr_q, wdata_q;
  logic        memr_q, memw_q;

  logic             in_idle;
  logic [31:0]      acc_addr, acc_wdata, acc_off;
  logic             acc_memr, acc_memw, acc_err;
  logic             enter_resp, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      memr_q  <= 1'b0;
      memw_q  <= 1'b0;
    end else if (in_idle && req) begin
      addr_q  <= addr;
      wdata_q <= wData;
      memr_q  <= memr;
      memw_q  <= memw;
    end
  end

  // With zero wait states the access completes on the acceptance edge, so use live inputs then.
  assign in_idle    = (state_q == IDLE);
  assign acc_addr   = in_idle ? addr  : addr_q;
  assign acc_wdata  = in_idle ? wData : wdata_q;
  assign acc_memr   = in_idle ? memr  : memr_q;
  assign acc_memw   = in_idle ? memw  : memw_q;
  assign acc_off    = acc_addr - BASE_ADDR;
  assign mem_idx    = IDX_W'(acc_off >> WORD_SHIFT);
  assign acc_err    = access_err(acc_addr, BASE_ADDR, acc_memr, acc_memw, DEPTH);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign mem_we     = enter_resp && acc_memw && !acc_err;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err) begin
        rdata_d = '0;
      end else if (acc_memr) begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_comb begin
    ack   = (state_q == RESP);
    busy  = (state_q == WAIT);
    rdata = rdata_q;
    err   = err_q;
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2/DEPTH=256 and LATENCY=0/DEPTH=16)
// checked every cycle against a transaction-level model plus literal expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        memr [2];
  logic        memw [2];
  logic [31:0] addr [2];
  logic [31:0] wData [2];
  logic        ack [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic        busy [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          pend;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rd;
    bit          do_wr;
    int          wkey;
    logic [31:0] wval;
  } pend_t;

  pend_t       pm [2];
  logic [31:0] last_rd [2];
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .memr(memr[0]), .memw(memw[0]),
    .addr(addr[0]), .wData(wData[0]), .ack(ack[0]), .rdata(rdata[0]),
    .err(err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .memr(memr[1]), .memw(memw[1]),
    .addr(addr[1]), .wData(wData[1]), .ack(ack[1]), .rdata(rdata[1]),
    .err(err[1]), .busy(busy[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 256 : 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record what the accepted request must produce, straight from the access rules.
  task automatic model_accept(input int i, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input int acc);
    bit e;
    int key;
    e   = (a % 4 != 0) || ((a / 4) >= 32'(depth_of(i))) || (r == w);
    key = i * 65536 + int'(a / 4);
    pm[i].pend    = 1'b1;
    pm[i].exp_cyc = acc + lat_of(i);
    pm[i].exp_err = e;
    pm[i].exp_rd  = e ? 32'h0 : (r ? (mem_m.exists(key) ? mem_m[key] : 32'h0) : last_rd[i]);
    pm[i].do_wr   = !e && w;
    pm[i].wkey    = key;
    pm[i].wval    = d;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit exp_ack;
    for (int i = 0; i < 2; i++) begin
      exp_ack = pm[i].pend && (cyc == pm[i].exp_cyc);
      check($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(exp_ack));
      check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(pm[i].pend && (cyc < pm[i].exp_cyc)));
      if (exp_ack) begin
        check($sformatf("err[%0d]", i), 32'(err[i]), 32'(pm[i].exp_err));
        check($sformatf("rdata_ack[%0d]", i), rdata[i], pm[i].exp_rd);
        last_rd[i] = pm[i].exp_rd;
        if (pm[i].do_wr) mem_m[pm[i].wkey] = pm[i].wval;
        pm[i].pend = 1'b0;
      end else begin
        check($sformatf("rdata_hold[%0d]", i), rdata[i], last_rd[i]);
        if (pm[i].pend && cyc > pm[i].exp_cyc) pm[i].pend = 1'b0;
      end
    end
  end

  // Issue one request; req is left high so the caller chooses back-to-back or idle.
  task automatic issue(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble,
                       output int acc, output int ackc, output logic e_seen,
                       output logic [31:0] rd_seen);
    addr[i]  = a;
    wData[i] = d;
    memr[i]  = r;
    memw[i]  = w;
    req[i]   = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    model_accept(i, r, w, a, d, acc);
    if (scramble) begin
      addr[i]  = ~a;
      wData[i] = ~d;
      memr[i]  = ~r;
      memw[i]  = ~w;
    end
    ackc    = -1;
    e_seen  = 1'bx;
    rd_seen = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack[i] === 1'b1) begin
        ackc    = cyc;
        e_seen  = err[i];
        rd_seen = rdata[i];
        break;
      end
    end
    if (ackc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout[%0d]: no ack within 40 cycles for addr %h", i, a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_a, ack_a, acc_b, ack_b;
    logic        e_a, e_b;
    logic [31:0] rd_a, rd_b;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; memr[i] = 1'b0; memw[i] = 1'b0; addr[i] = '0; wData[i] = '0;
      pm[i].pend = 1'b0; last_rd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack[0]), 32'h0);
    check("reset_busy", 32'(busy[0]), 32'h0);
    check("reset_err", 32'(err[0]), 32'h0);
    check("reset_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-WAIT drops the pending store to 0x10.
    issue(0, 1'b0, 1'b1, 32'h10, 32'h1111_0000, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    addr[0] = 32'h10; wData[0] = 32'hBAD0_BAD0; memr[0] = 1'b0; memw[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    #1;
    model_accept(0, 1'b0, 1'b1, 32'h10, 32'hBAD0_BAD0, cyc);
    @(posedge clk);
    #1;
    check("midwait_busy", 32'(busy[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    req[0] = 1'b0;
    pm[0].pend = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    #1;
    check("async_reset_busy", 32'(busy[0]), 32'h0);
    check("async_reset_rdata", rdata[0], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("reset_dropped_store", rd_a, 32'h1111_0000);

    // LATENCY=2 store/load.
    issue(0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("lat2_ack_delay", 32'(ack_a - acc_a + 1), 32'd3);
    check("lat2_store_err", 32'(e_a), 32'h0);
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("lat2_load_rdata", rd_a, 32'hDEAD_BEEF);

    // LATENCY=0 back-to-back store then load.
    issue(1, 1'b0, 1'b1, 32'h0, 32'h5, 1'b0, acc_a, ack_a, e_a, rd_a);
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, acc_b, ack_b, e_b, rd_b);
    idle(1);
    check("lat0_store_delay", 32'(ack_a - acc_a + 1), 32'd1);
    check("lat0_load_delay", 32'(ack_b - acc_b + 1), 32'd1);
    check("lat0_throughput", 32'(acc_b - acc_a), 32'd2);
    check("lat0_load_rdata", rd_b, 32'h5);

    // Misaligned load and out-of-range store leave the array alone.
    issue(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    issue(0, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("misaligned_err", 32'(e_a), 32'h1);
    check("misaligned_rdata", rd_a, 32'h0);
    issue(0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("range_err", 32'(e_a), 32'h1);
    issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("range_no_alias_write", rd_a, 32'hA5A5_A5A5);
    issue(1, 1'b0, 1'b1, 32'h40, 32'h7777_7777, 1'b0, acc_a, ack_a, e_a, rd_a);
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, acc_b, ack_b, e_b, rd_b);
    idle(1);
    check("small_range_err", 32'(e_a), 32'h1);
    check("small_no_alias_write", rd_b, 32'h5);

    // Both ops set with req held through RESP; next request accepted in the following IDLE.
    issue(0, 1'b0, 1'b1, 32'h30, 32'h1234_5678, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    issue(0, 1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, 1'b0, acc_a, ack_a, e_a, rd_a);
    issue(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, acc_b, ack_b, e_b, rd_b);
    issue(0, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, acc_b, ack_b, e_b, rd_b);
    idle(0);
    check("both_ops_err", 32'(e_a), 32'h1);
    check("held_req_throughput", 32'(acc_b - acc_a), 32'd8);
    check("no_op_err", 32'(e_b), 32'h1);
    issue(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("both_ops_no_write", rd_a, 32'h1234_5678);

    // Request fields changing during WAIT are ignored.
    issue(0, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b1, acc_a, ack_a, e_a, rd_a);
    idle(0);
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("scramble_store_load", rd_a, 32'hCAFE_F00D);
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, acc_a, ack_a, e_a, rd_a);
    idle(0);
    check("scramble_load", rd_a, 32'hDEAD_BEEF);
    check("scramble_load_err", 32'(e_a), 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
